imem_dmem_arbiter: RTL and testbench

//  Shares the single-ported unified memory between IF-stage fetch and MEM-stage load/store.

---
 rtl/imem_dmem_arbiter_pkg.sv | 23 ++
 rtl/imem_dmem_arbiter_mem_lat_counter.sv | 36 +++
 rtl/imem_dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: memory command encoding,
// arbiter states and the word-alignment helper.
package imem_dmem_arbiter_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10
  } mem_cmd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY_IF = 2'b01,
    BUSY_DM = 2'b10
  } arb_state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/imem_dmem_arbiter_mem_lat_counter.sv
// Load/decrement down counter that times one memory access; zero_c marks the
// completion cycle.
module imem_dmem_arbiter_mem_lat_counter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero_c
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and
// data load/store, sequencing a fixed access latency and driving stall flags.
module imem_dmem_arbiter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_flush,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_rvalid,
  output logic            if_stall,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  output logic [XLEN-1:0] dm_rdata,
  output logic            dm_rvalid,
  output logic            dm_stall,
  output logic [1:0]      mem_cmd,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int unsigned CNT_W    = $clog2(MEM_LATENCY + 1);
  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]    LAT_LOAD   = CNT_W'(MEM_LATENCY - 1);
  localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);

  arb_state_t          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                flushed_q, flushed_d;
  logic                grant_if, grant_dm, fetch_live, cnt_zero_c;

  imem_dmem_arbiter_mem_lat_counter #(.WIDTH(CNT_W)) u_lat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (grant_if | grant_dm),
    .dec      ((state_q != IDLE) & ~cnt_zero_c),
    .load_val (LAT_LOAD),
    .zero_c   (cnt_zero_c)
  );

  // Grant decision, memory command drive and completion handling
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    flushed_d  = flushed_q;
    grant_if   = 1'b0;
    grant_dm   = 1'b0;
    mem_cmd    = MEM_NONE;
    mem_addr   = '0;
    mem_wdata  = '0;
    if_rvalid  = 1'b0;
    if_rdata   = '0;
    dm_rvalid  = 1'b0;
    dm_rdata   = '0;
    fetch_live = if_req & ~if_flush;

    case (state_q)
      IDLE: begin
        if (rst_n) begin
          if (dm_req && !(fetch_live && (starve_q == STARVE_TOP))) begin
            grant_dm = 1'b1;
          end else if (fetch_live) begin
            grant_if = 1'b1;
          end
        end
      end
      BUSY_IF: begin
        if (if_flush) begin
          flushed_d = 1'b1;
        end
        // A fetch flushed while in flight still occupies the memory but never reports
        if (cnt_zero_c) begin
          if_rvalid = ~flushed_q & ~if_flush;
          if_rdata  = if_rvalid ? mem_rdata : '0;
          flushed_d = 1'b0;
          state_d   = IDLE;
        end
      end
      BUSY_DM: begin
        if (cnt_zero_c) begin
          dm_rvalid = 1'b1;
          dm_rdata  = mem_rdata;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_dm) begin
      mem_cmd   = dm_we ? MEM_STORE : MEM_LOAD;
      mem_addr  = word_align(dm_addr);
      mem_wdata = dm_we ? dm_wdata : '0;
      state_d   = BUSY_DM;
      if (fetch_live && (starve_q != STARVE_TOP)) begin
        starve_d = starve_q + STARVE_W'(1);
      end
    end else if (grant_if) begin
      mem_cmd   = MEM_LOAD;
      mem_addr  = word_align(if_addr);
      state_d   = BUSY_IF;
      starve_d  = '0;
      flushed_d = 1'b0;
    end
  end

  assign if_stall = rst_n & if_req & ~if_rvalid;
  assign dm_stall = rst_n & dm_req & ~dm_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      flushed_q <= flushed_d;
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter at MEM_LATENCY=2, STARVE_MAX=4.
module tb_imem_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic        if_rvalid;
  logic        if_stall;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_rvalid;
  logic        dm_stall;
  logic [1:0]  mem_cmd;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_checks;
  int n_errors;

  imem_dmem_arbiter #(.MEM_LATENCY(2), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_rdata  (if_rdata),
    .if_rvalid (if_rvalid),
    .if_stall  (if_stall),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_rvalid (dm_rvalid),
    .dm_stall  (dm_stall),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_cyc();
    @(negedge clk);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    if_req    = 1'b1;
    if_addr   = 32'h10;
    if_flush  = 1'b0;
    dm_req    = 1'b1;
    dm_we     = 1'b0;
    dm_addr   = 32'h200;
    dm_wdata  = 32'h0;
    mem_rdata = 32'h0;

    // Reset: everything quiet even with requests pending
    mid_cyc();
    chk("rst_cmd",    32'(mem_cmd),   32'd0);
    chk("rst_addr",   mem_addr,       32'h0);
    chk("rst_ifstl",  32'(if_stall),  32'd0);
    chk("rst_dmstl",  32'(dm_stall),  32'd0);
    chk("rst_ifrv",   32'(if_rvalid), 32'd0);
    chk("rst_dmrv",   32'(dm_rvalid), 32'd0);
    next_cyc();
    if_req = 1'b0;
    dm_req = 1'b0;
    rst_n  = 1'b1;
    next_cyc();

    // Test 1: single fetch
    if_req = 1'b1; if_addr = 32'h10; mem_rdata = 32'h1234_0001;
    mid_cyc();
    chk("t1_cmd",   32'(mem_cmd),  32'd1);
    chk("t1_addr",  mem_addr,      32'h10);
    chk("t1_stl0",  32'(if_stall), 32'd1);
    chk("t1_rv0",   32'(if_rvalid), 32'd0);
    next_cyc(); mid_cyc();
    chk("t1_cmd1",  32'(mem_cmd),  32'd0);
    chk("t1_stl1",  32'(if_stall), 32'd1);
    next_cyc(); mid_cyc();
    chk("t1_rv",    32'(if_rvalid), 32'd1);
    chk("t1_rdata", if_rdata,       32'h1234_0001);
    chk("t1_stl2",  32'(if_stall),  32'd0);
    next_cyc(); if_req = 1'b0; mid_cyc();
    chk("t1_idle",  32'(mem_cmd),  32'd0);

    // Test 2: simultaneous request, data wins
    next_cyc();
    if_req = 1'b1; if_addr = 32'h10;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; mem_rdata = 32'h5555_0200;
    mid_cyc();
    chk("t2_cmd",    32'(mem_cmd),  32'd1);
    chk("t2_addr",   mem_addr,      32'h200);
    chk("t2_ifstl",  32'(if_stall), 32'd1);
    chk("t2_dmstl",  32'(dm_stall), 32'd1);
    next_cyc(); mid_cyc();
    next_cyc(); mid_cyc();
    chk("t2_dmrv",   32'(dm_rvalid), 32'd1);
    chk("t2_dmdata", dm_rdata,       32'h5555_0200);
    chk("t2_ifrv0",  32'(if_rvalid), 32'd0);
    chk("t2_dmstl2", 32'(dm_stall),  32'd0);
    next_cyc(); dm_req = 1'b0; mem_rdata = 32'h6666_0010; mid_cyc();
    chk("t2_ifcmd",  32'(mem_cmd),  32'd1);
    chk("t2_ifaddr", mem_addr,      32'h10);
    next_cyc(); mid_cyc();
    next_cyc(); mid_cyc();
    chk("t2_ifrv",   32'(if_rvalid), 32'd1);
    chk("t2_ifdata", if_rdata,       32'h6666_0010);
    next_cyc(); if_req = 1'b0;

    // Test 3: starvation guard forces the fifth grant to fetch
    next_cyc();
    if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    mem_rdata = 32'h0000_0077;
    for (int g = 0; g < 6; g++) begin
      if (g > 0) next_cyc();
      mid_cyc();
      chk($sformatf("t3_grant%0d", g), mem_addr, (g == 4) ? 32'h10 : 32'h200);
      next_cyc(); next_cyc(); mid_cyc();
      chk($sformatf("t3_ifrv%0d", g), 32'(if_rvalid), 32'(g == 4));
      chk($sformatf("t3_dmrv%0d", g), 32'(dm_rvalid), 32'(g != 4));
    end
    next_cyc(); if_req = 1'b0; dm_req = 1'b0;

    // Test 4: flush of an in-flight fetch, then flush blocking an idle grant
    next_cyc();
    if_req = 1'b1; if_addr = 32'h20; mid_cyc();
    chk("t4_cmd",   32'(mem_cmd), 32'd1);
    chk("t4_addr",  mem_addr,     32'h20);
    next_cyc(); if_req = 1'b0; if_flush = 1'b1; mid_cyc();
    chk("t4_rv1",   32'(if_rvalid), 32'd0);
    next_cyc(); if_flush = 1'b0; mid_cyc();
    chk("t4_rv2",   32'(if_rvalid), 32'd0);
    chk("t4_data2", if_rdata,       32'h0);
    next_cyc(); if_req = 1'b1; if_addr = 32'h40; mid_cyc();
    chk("t4_ncmd",  32'(mem_cmd), 32'd1);
    chk("t4_naddr", mem_addr,     32'h40);
    next_cyc(); mid_cyc();
    next_cyc(); mid_cyc();
    chk("t4_nrv",   32'(if_rvalid), 32'd1);
    next_cyc(); if_req = 1'b1; if_flush = 1'b1; if_addr = 32'h44; mid_cyc();
    chk("t4_blk",   32'(mem_cmd), 32'd0);
    next_cyc(); if_flush = 1'b0; mid_cyc();
    chk("t4_bcmd",  32'(mem_cmd), 32'd1);
    chk("t4_baddr", mem_addr,     32'h44);
    next_cyc(); next_cyc(); mid_cyc();
    chk("t4_brv",   32'(if_rvalid), 32'd1);
    next_cyc(); if_req = 1'b0;

    // Test 5: misaligned store; flush and requester changes do not disturb it
    next_cyc();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h103; dm_wdata = 32'hDEAD_BEEF; mid_cyc();
    chk("t5_cmd",   32'(mem_cmd), 32'd2);
    chk("t5_addr",  mem_addr,     32'h100);
    chk("t5_wdata", mem_wdata,    32'hDEAD_BEEF);
    next_cyc(); dm_addr = 32'h300; dm_wdata = 32'h0; if_flush = 1'b1; mid_cyc();
    chk("t5_cmd1",  32'(mem_cmd),   32'd0);
    chk("t5_rv1",   32'(dm_rvalid), 32'd0);
    chk("t5_stl1",  32'(dm_stall),  32'd1);
    next_cyc(); if_flush = 1'b0; mid_cyc();
    chk("t5_rv",    32'(dm_rvalid), 32'd1);
    chk("t5_ifrv",  32'(if_rvalid), 32'd0);
    next_cyc(); dm_req = 1'b0; dm_we = 1'b0;

    // Test 6: async reset mid-fetch
    next_cyc();
    if_req = 1'b1; if_addr = 32'h80; mem_rdata = 32'h0000_8080; mid_cyc();
    chk("t6_cmd",   32'(mem_cmd), 32'd1);
    next_cyc(); rst_n = 1'b0; #1;
    chk("t6_rcmd",  32'(mem_cmd),   32'd0);
    chk("t6_raddr", mem_addr,       32'h0);
    chk("t6_rstl",  32'(if_stall),  32'd0);
    chk("t6_rrv",   32'(if_rvalid), 32'd0);
    next_cyc(); mid_cyc();
    chk("t6_hrv",   32'(if_rvalid), 32'd0);
    chk("t6_hstl",  32'(if_stall),  32'd0);
    next_cyc(); rst_n = 1'b1; mid_cyc();
    chk("t6_ncmd",  32'(mem_cmd),   32'd1);
    chk("t6_naddr", mem_addr,       32'h80);
    chk("t6_nrv0",  32'(if_rvalid), 32'd0);
    next_cyc(); mid_cyc();
    chk("t6_nrv1",  32'(if_rvalid), 32'd0);
    next_cyc(); mid_cyc();
    chk("t6_nrv2",  32'(if_rvalid), 32'd1);
    chk("t6_ndata", if_rdata,       32'h0000_8080);
    next_cyc(); if_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
